// File: rtl/spn_decrypt_sequencer.sv
// Iterative decryption round controller for a 64-bit SPN cipher.
// Runs ROUNDS inverse rounds (key-add, inverse permutation, inverse
// substitution) on one held block, sharing a single external inverse
// S-box across all nibbles, one nibble per cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a ciphertext block; start_ready high
// KEY    | XOR round key rk_data (index round) into the state
// PERM   | apply the inverse bit permutation to the whole state
// SUB    | substitute nibble nib through the external inverse S-box
// DONE   | plaintext on data_out; hold until out_ready
module spn_decrypt_sequencer #(
  parameter int BLOCKSIZE = 4,
  parameter int DATA_W    = 64,
  parameter int ROUNDS    = 8,
  parameter int KIDX_W    = $clog2(ROUNDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [DATA_W-1:0]    data_in,
  output logic [KIDX_W-1:0]    rk_idx,
  input  logic [DATA_W-1:0]    rk_data,
  output logic [BLOCKSIZE-1:0] sbox_in,
  input  logic [BLOCKSIZE-1:0] sbox_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    data_out,
  output logic                 busy
);

  localparam int NIB   = DATA_W / BLOCKSIZE;
  localparam int NIB_W = $clog2(NIB);
  localparam logic [NIB_W-1:0]  NIB_LAST   = NIB_W'(NIB - 1);
  localparam logic [KIDX_W-1:0] ROUND_INIT = KIDX_W'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_PERM,
    S_SUB,
    S_DONE
  } state_t;

  state_t            fsm;
  logic [DATA_W-1:0] st;
  logic [DATA_W-1:0] st_perm;
  logic [KIDX_W-1:0] round;
  logic [NIB_W-1:0]  nib;
  logic [NIB_W-1:0]  nib_inc;

  // Plaintext is read straight from the state register.
  assign data_out = st;
  assign nib_inc  = nib + 1'b1;

  // Inverse permutation: input bit i lands on bit (BLOCKSIZE*i mod DATA_W-1); top bit is fixed.
  always_comb begin
    st_perm = '0;
    for (int i = 0; i < DATA_W - 1; i++) begin
      st_perm[(BLOCKSIZE * i) % (DATA_W - 1)] = st[i];
    end
    st_perm[DATA_W-1] = st[DATA_W-1];
  end

  // Round sequencing FSM; all outputs are registered and set up one cycle ahead of use.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= S_IDLE;
      st          <= '0;
      round       <= ROUND_INIT;
      nib         <= '0;
      start_ready <= 1'b0;
      out_valid   <= 1'b0;
      rk_idx      <= '0;
      sbox_in     <= '0;
      busy        <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          start_ready <= 1'b1;
          if (start_valid && start_ready) begin
            st          <= data_in;
            round       <= ROUND_INIT;
            rk_idx      <= ROUND_INIT;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            fsm         <= S_KEY;
          end
        end

        S_KEY: begin
          st     <= st ^ rk_data;
          rk_idx <= '0;
          if (round == '0) begin
            out_valid <= 1'b1;
            fsm       <= S_DONE;
          end else begin
            fsm <= S_PERM;
          end
        end

        S_PERM: begin
          st      <= st_perm;
          nib     <= '0;
          // First nibble of the permuted state is what SUB looks up first.
          sbox_in <= st_perm[BLOCKSIZE-1:0];
          fsm     <= S_SUB;
        end

        S_SUB: begin
          st[BLOCKSIZE*nib +: BLOCKSIZE] <= sbox_out;
          if (nib == NIB_LAST) begin
            nib     <= '0;
            round   <= round - 1'b1;
            rk_idx  <= round - 1'b1;
            sbox_in <= '0;
            fsm     <= S_KEY;
          end else begin
            // Next nibble is untouched by this cycle's write, so read it from st.
            nib     <= nib_inc;
            sbox_in <= st[BLOCKSIZE*nib_inc +: BLOCKSIZE];
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            fsm         <= S_IDLE;
          end
        end

        default: begin
          fsm         <= S_IDLE;
          start_ready <= 1'b0;
          out_valid   <= 1'b0;
          rk_idx      <= '0;
          sbox_in     <= '0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
